// File: rtl/imc22_npu_sched.sv
// IMC-22 NPU job scheduler: queues host jobs, issues NPU config writes and start,
// watches for done under a watchdog and returns tagged results over a response handshake.
module imc22_npu_sched #(
  parameter int CMD_DEPTH      = 4,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TAG_W          = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [9:0]                   cmd_base,
  input  logic [7:0]                   cmd_len,
  input  logic [TAG_W-1:0]             cmd_tag,
  input  logic                         flush,
  output logic [7:0]                   npu_cfg_addr,
  output logic [31:0]                  npu_cfg_wdata,
  output logic                         npu_cfg_wr,
  output logic                         npu_start,
  input  logic                         npu_done,
  input  logic [31:0]                  npu_result,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [TAG_W-1:0]             rsp_tag,
  output logic [31:0]                  rsp_data,
  output logic                         rsp_timeout,
  output logic                         busy,
  output logic [$clog2(CMD_DEPTH):0]   queue_count
);

  localparam int PW = $clog2(CMD_DEPTH);
  localparam int CW = PW + 1;
  localparam int WW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CW-1:0] FULL_C  = CW'(CMD_DEPTH);
  localparam logic [CW-1:0] CONE_C  = CW'(1);
  localparam logic [PW-1:0] PONE_C  = PW'(1);
  localparam logic [WW-1:0] WONE_C  = WW'(1);
  localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, CFG_BASE, CFG_LEN, START, WAIT, RESP} state_t;

  logic [9:0]       base_mem_r [CMD_DEPTH];
  logic [7:0]       len_mem_r  [CMD_DEPTH];
  logic [TAG_W-1:0] tag_mem_r  [CMD_DEPTH];
  logic [PW-1:0]    wr_ptr_r, rd_ptr_r;
  logic [CW-1:0]    count_r, count_nxt_s;
  logic             push_s, pop_s;
  state_t           state_r;
  logic [7:0]       job_len_r;
  logic [WW-1:0]    wdog_r;

  // A push in a flush cycle is dropped; popping is likewise held off by flush.
  assign push_s      = cmd_valid && cmd_ready && !flush;
  assign pop_s       = (state_r == IDLE) && (count_r != '0) && !flush;
  assign queue_count = count_r;

  // Next occupancy of the command queue.
  always_comb begin
    count_nxt_s = count_r;
    if (flush) begin
      count_nxt_s = '0;
    end else if (push_s && !pop_s) begin
      count_nxt_s = count_r + CONE_C;
    end else if (pop_s && !push_s) begin
      count_nxt_s = count_r - CONE_C;
    end else begin
      count_nxt_s = count_r;
    end
  end

  // Queue payload storage.
  always_ff @(posedge clk) begin
    if (push_s) begin
      base_mem_r[wr_ptr_r] <= cmd_base;
      len_mem_r[wr_ptr_r]  <= cmd_len;
      tag_mem_r[wr_ptr_r]  <= cmd_tag;
    end
  end

  // Queue pointers, occupancy and registered ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r  <= '0;
      rd_ptr_r  <= '0;
      count_r   <= '0;
      cmd_ready <= 1'b1;
    end else if (flush) begin
      wr_ptr_r  <= '0;
      rd_ptr_r  <= '0;
      count_r   <= '0;
      cmd_ready <= 1'b1;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PONE_C;
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PONE_C;
      count_r   <= count_nxt_s;
      cmd_ready <= (count_nxt_s != FULL_C);
    end
  end

  // Job sequencing FSM; every NPU/host output is registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= IDLE;
      job_len_r     <= 8'h00;
      wdog_r        <= '0;
      npu_cfg_addr  <= 8'h00;
      npu_cfg_wdata <= 32'h0;
      npu_cfg_wr    <= 1'b0;
      npu_start     <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_tag       <= '0;
      rsp_data      <= 32'h0;
      rsp_timeout   <= 1'b0;
      busy          <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (pop_s) begin
            state_r       <= CFG_BASE;
            busy          <= 1'b1;
            job_len_r     <= len_mem_r[rd_ptr_r];
            rsp_tag       <= tag_mem_r[rd_ptr_r];
            npu_cfg_wr    <= 1'b1;
            npu_cfg_addr  <= 8'h00;
            npu_cfg_wdata <= {22'b0, base_mem_r[rd_ptr_r]};
          end
        end
        CFG_BASE: begin
          state_r       <= CFG_LEN;
          npu_cfg_addr  <= 8'h04;
          npu_cfg_wdata <= {24'b0, job_len_r};
        end
        CFG_LEN: begin
          state_r       <= START;
          npu_cfg_wr    <= 1'b0;
          npu_cfg_addr  <= 8'h00;
          npu_cfg_wdata <= 32'h0;
          npu_start     <= 1'b1;
          wdog_r        <= '0;
        end
        START: begin
          // The watchdog counts the start cycle, so expiry lands TIMEOUT_CYCLES after start.
          state_r   <= WAIT;
          npu_start <= 1'b0;
          wdog_r    <= wdog_r + WONE_C;
        end
        WAIT: begin
          if (npu_done) begin
            state_r     <= RESP;
            rsp_valid   <= 1'b1;
            rsp_data    <= npu_result;
            rsp_timeout <= 1'b0;
          end else if (wdog_r == WD_LAST) begin
            state_r     <= RESP;
            rsp_valid   <= 1'b1;
            rsp_data    <= 32'h0;
            rsp_timeout <= 1'b1;
          end else begin
            wdog_r <= wdog_r + WONE_C;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state_r     <= IDLE;
            rsp_valid   <= 1'b0;
            rsp_data    <= 32'h0;
            rsp_timeout <= 1'b0;
            busy        <= 1'b0;
            wdog_r      <= '0;
          end
        end
        default: begin
          state_r    <= IDLE;
          npu_cfg_wr <= 1'b0;
          npu_start  <= 1'b0;
          rsp_valid  <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imc22_npu_sched.sv
// Scoreboard bench for imc22_npu_sched: a bench-side NPU model answers each start per a
// per-job plan, and every handshaken response is checked against the queued expectation.
module tb_imc22_npu_sched;

  localparam int TAG_W = 4;
  localparam int TMO   = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [9:0]       cmd_base = 10'h0;
  logic [7:0]       cmd_len = 8'h0;
  logic [TAG_W-1:0] cmd_tag = 4'h0;
  logic             flush = 1'b0;
  logic [7:0]       npu_cfg_addr;
  logic [31:0]      npu_cfg_wdata;
  logic             npu_cfg_wr;
  logic             npu_start;
  logic             npu_done;
  logic [31:0]      npu_result;
  logic             rsp_valid;
  logic             rsp_ready = 1'b1;
  logic [TAG_W-1:0] rsp_tag;
  logic [31:0]      rsp_data;
  logic             rsp_timeout;
  logic             busy;
  logic [2:0]       queue_count;

  logic             resp_done = 1'b0;
  logic             stray_done = 1'b0;
  logic [31:0]      resp_result = 32'h0;

  assign npu_done   = resp_done | stray_done;
  assign npu_result = resp_done ? resp_result : 32'hDEAD_BEEF;

  imc22_npu_sched #(.CMD_DEPTH(4), .TIMEOUT_CYCLES(TMO), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_base(cmd_base), .cmd_len(cmd_len), .cmd_tag(cmd_tag), .flush(flush),
    .npu_cfg_addr(npu_cfg_addr), .npu_cfg_wdata(npu_cfg_wdata), .npu_cfg_wr(npu_cfg_wr),
    .npu_start(npu_start), .npu_done(npu_done), .npu_result(npu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_tag(rsp_tag), .rsp_data(rsp_data),
    .rsp_timeout(rsp_timeout), .busy(busy), .queue_count(queue_count)
  );

  always #5 clk = ~clk;

  typedef struct { logic [TAG_W-1:0] tag; logic [31:0] data; logic tmo; int lat; } exp_t;
  typedef struct { int k; logic [31:0] res; } plan_t;

  exp_t  sb[$];
  plan_t plans[$];
  exp_t  mon_e;
  plan_t cur_plan;
  int    errors = 0;
  int    checks = 0;
  int    cyc = 0;
  int    start_cyc = 0;
  logic  prev_valid = 1'b0;
  int    exp_cnt [5] = '{0, 1, 1, 2, 3};

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic chk_cfg(input string nm, input logic s, input logic w, input logic [7:0] a,
                         input logic [31:0] d);
    check_eq(nm, {22'b0, npu_start, npu_cfg_wr, npu_cfg_addr, npu_cfg_wdata}, {22'b0, s, w, a, d});
  endtask

  task automatic reset_chk(input string nm);
    check_eq({nm, "_ctrl"}, {43'b0, cmd_ready, npu_cfg_wr, npu_start, rsp_valid, rsp_timeout,
             busy, queue_count, rsp_tag, npu_cfg_addr}, {43'b0, 1'b1, 20'b0});
    check_eq({nm, "_data"}, {npu_cfg_wdata, rsp_data}, 64'h0);
  endtask

  // k = WAIT cycle (1 = first) in which done is raised, 0 = never (watchdog expiry).
  task automatic expect_job(input logic [TAG_W-1:0] t, input int k, input logic [31:0] res);
    plan_t p;
    exp_t  e;
    p.k = k; p.res = res;
    plans.push_back(p);
    e.tag  = t;
    e.data = (k > 0) ? res : 32'h0;
    e.tmo  = (k == 0);
    e.lat  = (k > 0) ? k + 1 : TMO;
    sb.push_back(e);
  endtask

  task automatic push_job(input logic [9:0] b, input logic [7:0] l, input logic [TAG_W-1:0] t,
                          input bit run, input int k, input logic [31:0] res);
    int n = 0;
    cmd_base = b; cmd_len = l; cmd_tag = t; cmd_valid = 1'b1;
    @(negedge clk);
    while (!cmd_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (n >= 100) check_eq("push_timeout", 64'(n), 64'd0);
    if (run) expect_job(t, k, res);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    @(negedge clk);
    while (!(sb.size() == 0 && !busy && queue_count == 3'd0) && n < limit) begin
      n++;
      @(negedge clk);
    end
    check_eq("drain_timeout", 64'(n >= limit), 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic wait_start(input string nm);
    int n = 0;
    @(negedge clk);
    while (!npu_start && n < 50) begin
      n++;
      @(negedge clk);
    end
    check_eq(nm, 64'(n >= 50), 64'd0);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Bench NPU: answers each start according to the oldest outstanding plan.
  initial forever begin
    @(negedge clk);
    if (rst_n && npu_start) begin
      start_cyc = cyc;
      if (plans.size() > 0) begin
        cur_plan = plans.pop_front();
        if (cur_plan.k > 0) begin
          repeat (cur_plan.k) @(posedge clk);
          #1; resp_done = 1'b1; resp_result = cur_plan.res;
          @(posedge clk);
          #1; resp_done = 1'b0;
        end
      end
    end
  end

  // Response monitor: latency on rsp_valid rise, payload on handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rsp_valid && !prev_valid) begin
        if (sb.size() == 0) check_eq("unexpected_rsp", {60'b0, rsp_tag}, 64'hFFFF);
        else check_eq("rsp_latency", 64'(cyc - start_cyc), 64'(sb[0].lat));
      end
      if (rsp_valid && rsp_ready && sb.size() > 0) begin
        mon_e = sb.pop_front();
        check_eq("rsp_tag", {60'b0, rsp_tag}, {60'b0, mon_e.tag});
        check_eq("rsp_data", {32'b0, rsp_data}, {32'b0, mon_e.data});
        check_eq("rsp_timeout", {63'b0, rsp_timeout}, {63'b0, mon_e.tmo});
      end
    end
    prev_valid <= rsp_valid;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int n;
    logic [TAG_W-1:0] hold_tag;
    logic [31:0] hold_data;
    int bad;

    repeat (3) @(posedge clk);
    #1 reset_chk("reset");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Single job: config sequence, start pulse, result with tag.
    push_job(10'h040, 8'd4, 4'd3, 1'b1, 6, 32'h0000_1234);
    @(negedge clk) chk_cfg("t1_idle", 1'b0, 1'b0, 8'h00, 32'h0);
    @(negedge clk) chk_cfg("t1_cfg_base", 1'b0, 1'b1, 8'h00, 32'h40);
    @(negedge clk) chk_cfg("t1_cfg_len", 1'b0, 1'b1, 8'h04, 32'h4);
    @(negedge clk) chk_cfg("t1_start", 1'b1, 1'b0, 8'h00, 32'h0);
    @(negedge clk) chk_cfg("t1_wait", 1'b0, 1'b0, 8'h00, 32'h0);
    check_eq("t1_busy", {63'b0, busy}, 64'd1);
    wait_idle(100);

    // Five back-to-back pushes against a slow first job.
    for (int i = 0; i < 5; i++) begin
      cmd_base = 10'(16 * i); cmd_len = 8'(i); cmd_tag = 4'(8 + i); cmd_valid = 1'b1;
      expect_job(4'(8 + i), (i == 0) ? 12 : 2, 32'h100 + 32'(i));
      @(negedge clk);
      check_eq($sformatf("t2_cnt%0d", i), {61'b0, queue_count}, 64'(exp_cnt[i]));
      check_eq($sformatf("t2_rdy%0d", i), {63'b0, cmd_ready}, 64'd1);
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    @(negedge clk);
    check_eq("t2_full_cnt", {61'b0, queue_count}, 64'd4);
    check_eq("t2_full_rdy", {63'b0, cmd_ready}, 64'd0);
    @(posedge clk); #1;
    wait_idle(400);

    // Watchdog expiry, then a normal job; then done exactly in the expiry cycle.
    push_job(10'h3FF, 8'd1, 4'd1, 1'b1, 0, 32'h0);
    push_job(10'h001, 8'd2, 4'd2, 1'b1, 3, 32'h5555_0002);
    wait_idle(200);
    push_job(10'h002, 8'd0, 4'd4, 1'b1, TMO - 1, 32'h0000_00AA);
    wait_idle(100);

    // Back-pressure on the response with two jobs queued.
    rsp_ready = 1'b0;
    push_job(10'h050, 8'd5, 4'd5, 1'b1, 2, 32'h50);
    push_job(10'h123, 8'd7, 4'd6, 1'b1, 3, 32'h60);
    push_job(10'h070, 8'd9, 4'd7, 1'b1, 1, 32'h70);
    n = 0;
    @(negedge clk);
    while (!rsp_valid && n < 100) begin
      n++;
      @(negedge clk);
    end
    check_eq("t5_rsp_wait", 64'(n >= 100), 64'd0);
    check_eq("t5_qcnt", {61'b0, queue_count}, 64'd2);
    hold_tag = rsp_tag; hold_data = rsp_data; bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (!rsp_valid || rsp_tag !== hold_tag || rsp_data !== hold_data || rsp_timeout ||
          npu_cfg_wr || npu_start) bad++;
    end
    check_eq("t5_hold", 64'(bad), 64'd0);
    check_eq("t5_hold_tag", {60'b0, hold_tag}, 64'd5);
    @(posedge clk); #1 rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk) chk_cfg("t5_gap", 1'b0, 1'b0, 8'h00, 32'h0);
    @(negedge clk) chk_cfg("t5_cfg_base", 1'b0, 1'b1, 8'h00, 32'h123);
    @(posedge clk); #1 stray_done = 1'b1;
    @(negedge clk) chk_cfg("t5_cfg_len", 1'b0, 1'b1, 8'h04, 32'h7);
    @(posedge clk); #1 stray_done = 1'b0;
    wait_idle(200);

    // Flush with a concurrent push during the first job's WAIT.
    push_job(10'h090, 8'd3, 4'd9, 1'b1, 10, 32'h90);
    push_job(10'h0A0, 8'd3, 4'd10, 1'b0, 0, 32'h0);
    push_job(10'h0B0, 8'd3, 4'd11, 1'b0, 0, 32'h0);
    wait_start("t6_start_wait");
    @(posedge clk); #1;
    flush = 1'b1; cmd_valid = 1'b1; cmd_tag = 4'd12; cmd_base = 10'h0C0;
    @(negedge clk) check_eq("t6_pre_flush", {61'b0, queue_count}, 64'd2);
    @(posedge clk); #1 flush = 1'b0; cmd_valid = 1'b0;
    @(negedge clk);
    check_eq("t6_flushed_cnt", {61'b0, queue_count}, 64'd0);
    check_eq("t6_flushed_rdy", {63'b0, cmd_ready}, 64'd1);
    check_eq("t6_inflight_busy", {63'b0, busy}, 64'd1);
    @(posedge clk); #1;
    wait_idle(100);
    repeat (10) @(negedge clk);
    check_eq("t6_no_lost_job", {62'b0, busy, npu_cfg_wr}, 64'd0);

    // Reset in the middle of WAIT drops the job without a response.
    @(posedge clk); #1;
    push_job(10'h0D0, 8'd1, 4'd13, 1'b0, 0, 32'h0);
    wait_start("t6r_start_wait");
    repeat (5) @(negedge clk);
    #3 rst_n = 1'b0;
    #1 reset_chk("t6_midrst");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    check_eq("t6_after_rst", {60'b0, busy, rsp_valid, npu_start, npu_cfg_wr}, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/imc22_npu_sched.md
Name: imc22_npu_sched

Overview:
Job scheduler that sequences the IMC-22 NPU on behalf of the host (RISC-V CPU or debug master).
- Host pushes jobs (SRAM base, length, tag) into a small command queue.
- Per job, the scheduler performs the NPU config writes, pulses start, waits for done with a watchdog, and returns the result with its tag through a response handshake.
- Replaces the fixed-cycle start stub in the system top.

Parameters:
CMD_DEPTH, 4, command queue entries; power of 2, minimum 2.
TIMEOUT_CYCLES, 1024, max WAIT cycles before a job is declared timed out; minimum 2.
TAG_W, 4, width of the job tag.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  host job request
cmd_ready  out  1  queue can accept a job
cmd_base  in  10  SRAM byte base address of job operands
cmd_len  in  8  number of 16-byte operand rows
cmd_tag  in  TAG_W  host job identifier
flush  in  1  one-cycle pulse; discards all queued (not yet started) jobs
npu_cfg_addr  out  8  NPU config register address
npu_cfg_wdata  out  32  NPU config write data
npu_cfg_wr  out  1  NPU config write strobe
npu_start  out  1  one-cycle NPU start pulse
npu_done  in  1  NPU completion pulse
npu_result  in  32  NPU result, valid while npu_done=1
rsp_valid  out  1  response available
rsp_ready  in  1  host accepts response
rsp_tag  out  TAG_W  tag of completed job
rsp_data  out  32  NPU result, or 0 on timeout
rsp_timeout  out  1  job ended by watchdog
busy  out  1  state != IDLE
queue_count  out  clog2(CMD_DEPTH)+1  occupied queue entries

Behaviour:
Reset and clocking:
- Single clock domain; rst_n is asynchronous assert, active-low.
- On reset: all outputs 0 except cmd_ready=1. Queue is empty, state is IDLE, watchdog counter is 0.
- Reset asserted mid-job drops the job silently; no response is produced.

Command queue:
- FIFO of {base, len, tag}.
- cmd_ready = !full; a push occurs when cmd_valid && cmd_ready.
- A push and a pop in the same cycle are allowed; queue_count is unchanged.
- Push attempted while full is ignored (cmd_ready=0).
- Pointers wrap modulo CMD_DEPTH.
- flush empties the queue at the next edge.
  - A push in the same cycle as flush is discarded.
  - flush does not affect the job in progress or a pending response.

FSM:
- IDLE: if queue non-empty and flush=0, pop the head into job registers and go to CFG_BASE.
- CFG_BASE (1 cycle): npu_cfg_wr=1, npu_cfg_addr=0x00, npu_cfg_wdata={22'b0, base}. Next state CFG_LEN.
- CFG_LEN (1 cycle): npu_cfg_wr=1, npu_cfg_addr=0x04, npu_cfg_wdata={24'b0, len}. Next state START.
- START (1 cycle): npu_start=1; watchdog counter cleared. Next state WAIT.
- WAIT: counter increments each cycle.
  - npu_done=1: capture npu_result, rsp_timeout=0, go to RESP.
  - Else, counter == TIMEOUT_CYCLES-1: rsp_data=0, rsp_timeout=1, go to RESP.
  - npu_done in the expiry cycle: done wins.
- RESP: rsp_valid=1, and rsp_tag/rsp_data/rsp_timeout are held stable until rsp_ready. On the handshake edge go to IDLE; the next job can be popped in the following cycle.

Other rules:
- npu_done outside WAIT is ignored.
- npu_cfg_wr and npu_start are never high together and are 0 in all other states.
- cmd_len=0 is legal and forwarded unchanged.
- Latency: handshake at edge T into an empty queue with the FSM idle gives the CFG_BASE write in cycle T+1→T+2, npu_start in cycle T+3→T+4, and the minimum job round trip of handshake to rsp_valid is 5 cycles when done comes the first WAIT cycle.

Test Plan:
1. Reset, push {base=0x040, len=4, tag=3}, NPU done 6 cycles after start with result 0x0000_1234 -> cfg writes (0x00, 0x40) then (0x04, 0x4) on consecutive cycles, then one start pulse; rsp_valid with tag=3, data=0x1234, timeout=0; busy drops after rsp_ready.
2. Push 5 jobs back-to-back with CMD_DEPTH=4 while the NPU is stalled -> first job popped, next 4 fill the queue; cmd_ready=0 only once queue_count=4; responses return tags in push order.
3. Never assert npu_done, TIMEOUT_CYCLES=16 -> rsp_valid exactly 16 cycles after the start pulse, with rsp_timeout=1 and rsp_data=0; next job proceeds normally.
4. npu_done in the exact watchdog expiry cycle with result 0xAA -> rsp_timeout=0, rsp_data=0xAA.
5. Hold rsp_ready=0 for 20 cycles with 2 jobs queued -> outputs stable and no new cfg writes or start pulses; release gives the second job's CFG_BASE 2 cycles after the handshake. Also inject npu_done during CFG_LEN -> ignored.
6. Queue 3 jobs, pulse flush together with cmd_valid during the first job's WAIT -> queue_count=0 next cycle and the pushed job is lost; the in-flight job still responds; asserting rst_n low mid-WAIT -> all outputs go to reset values immediately and no response is issued.
